// File: rtl/spi_master_core_if.sv
// Bundle of the register-file handshake, configuration and SPI pin signals
// for spi_master_core. The master modport is the shift engine's view; the
// slave modport is the register file / pad side.
interface spi_master_core_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 8
);
  logic                  cfg_cpol;
  logic                  cfg_cpha;
  logic [DIV_WIDTH-1:0]  cfg_clk_div;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  cfg_cpol, cfg_cpha, cfg_clk_div, tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output cfg_cpol, cfg_cpha, cfg_clk_div, tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_core.sv
// SPI master shift engine: one word per transfer, MSB first, all four
// CPOL/CPHA modes, programmable half-period divider. Configuration is
// latched at accept so mid-frame register writes cannot disturb a frame.
module spi_master_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input logic             clock,
  input logic             reset,
  spi_master_core_if.master bus
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  div_cfg_q, div_cfg_d;
  logic [EdgeW-1:0]      edge_q, edge_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;

  logic                  take_edge;
  logic [EdgeW-1:0]      edge_next;
  logic                  edge_odd;
  logic                  do_sample;
  logic                  do_present;

  // Next-state logic: FSM sequencing, divider, edge counter and shifters.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cfg_d  = div_cfg_q;
    edge_d     = edge_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    take_edge  = 1'b0;
    edge_next  = edge_q + 1'b1;
    edge_odd   = edge_next[0];
    do_sample  = 1'b0;
    do_present = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Idle level tracks the live CPOL input until a frame is accepted.
        sclk_d = bus.cfg_cpol;
        if (bus.tx_valid) begin
          state_d    = StLead;
          cpol_d     = bus.cfg_cpol;
          cpha_d     = bus.cfg_cpha;
          div_cfg_d  = bus.cfg_clk_div;
          div_d      = bus.cfg_clk_div;
          edge_d     = '0;
          rx_shift_d = '0;
          if (!bus.cfg_cpha) begin
            // CPHA=0 must have the MSB on the wire before the first edge.
            mosi_d     = bus.tx_data[DATA_WIDTH-1];
            tx_shift_d = bus.tx_data << 1;
          end else begin
            tx_shift_d = bus.tx_data;
          end
        end
      end
      StLead: begin
        if (div_q == '0) begin
          state_d   = StXfer;
          div_d     = div_cfg_q;
          take_edge = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StXfer: begin
        if (div_q == '0) begin
          div_d = div_cfg_q;
          if (edge_q == LastEdge) begin
            state_d = StTrail;
            sclk_d  = cpol_q;
          end else begin
            take_edge = 1'b1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StTrail: begin
        sclk_d = cpol_q;
        if (div_q == '0) begin
          state_d    = StIdle;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // SCLK edge k: toggle, then sample or present depending on phase.
    if (take_edge) begin
      edge_d     = edge_next;
      sclk_d     = ~sclk_q;
      do_sample  = cpha_q ? ~edge_odd : edge_odd;
      do_present = cpha_q ? edge_odd : (~edge_odd && (edge_next != LastEdge));
      if (do_sample) begin
        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
      end
      if (do_present) begin
        mosi_d     = tx_shift_q[DATA_WIDTH-1];
        tx_shift_d = tx_shift_q << 1;
      end
    end

    cs_n_d = (state_d == StIdle);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      div_cfg_q  <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cfg_q  <= div_cfg_d;
      edge_q     <= edge_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  // Output drive: SPI pins straight from flops, handshake from state.
  always_comb begin
    bus.tx_ready = (state_q == StIdle);
    bus.busy     = (state_q != StIdle);
    bus.rx_data  = rx_data_q;
    bus.rx_valid = rx_valid_q;
    bus.sclk     = sclk_q;
    bus.mosi     = mosi_q;
    bus.cs_n     = cs_n_q;
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: modes 0/2/3, loopback and slave
// model, back-to-back frames, mid-frame config changes, reset mid-frame,
// ignored requests while busy and the maximum divider.
module tb_spi_master_core;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 8;

  logic clock = 1'b0;
  logic reset;
  logic loopback;
  logic slave_bit;
  int   tests = 0;
  int   fails = 0;

  spi_master_core_if #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) bus_if ();

  spi_master_core #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  assign bus_if.miso = loopback ? bus_if.mosi : slave_bit;

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request in cycle 0 and step into cycle 1.
  task automatic start(input logic cpol, input logic cpha, input logic [VW-1:0] div,
                       input logic [DW-1:0] data);
    bus_if.cfg_cpol    = cpol;
    bus_if.cfg_cpha    = cpha;
    bus_if.cfg_clk_div = div;
    bus_if.tx_data     = data;
    bus_if.tx_valid    = 1'b1;
    check("accept_ready", 32'(bus_if.tx_ready), 32'd1);
    tick();
    bus_if.tx_valid = 1'b0;
  endtask

  // Observe a frame from cycle 1 until rx_valid; slave drives sw MSB first.
  // poke_kind 1 rewrites cfg mid-frame, 2 pulses tx_valid for one cycle.
  task automatic watch(input int budget, input logic cpha, input logic [DW-1:0] sw_in,
                       input int poke_at, input int poke_kind,
                       output int low, output int rises, output logic [DW-1:0] mbits,
                       output int vcyc, output logic [DW-1:0] rx, output int rdy);
    logic          prev_sclk;
    int            e;
    logic [DW-1:0] sw;
    low = 0; rises = 0; mbits = '0; vcyc = -1; rx = '0; rdy = 0; e = 0; sw = sw_in;
    prev_sclk = bus_if.sclk;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc == poke_at && poke_kind == 1) begin
        bus_if.cfg_cpol    = 1'b1;
        bus_if.cfg_clk_div = 8'd5;
      end
      if (cyc == poke_at && poke_kind == 2) begin
        bus_if.tx_data  = 8'hCC;
        bus_if.tx_valid = 1'b1;
      end
      if (cyc == poke_at + 1 && poke_kind == 2) bus_if.tx_valid = 1'b0;
      if (bus_if.rx_valid) begin
        vcyc = cyc;
        rx   = bus_if.rx_data;
        break;
      end
      if (!bus_if.cs_n) low++;
      if (bus_if.tx_ready) rdy++;
      if (cyc == 1 && !cpha) begin
        slave_bit = sw[DW-1];
        sw = sw << 1;
      end
      if (bus_if.sclk != prev_sclk) begin
        e++;
        if (bus_if.sclk) begin
          rises++;
          mbits = {mbits[DW-2:0], bus_if.mosi};
        end
        if ((cpha && e[0]) || (!cpha && !e[0] && e < 2 * DW)) begin
          slave_bit = sw[DW-1];
          sw = sw << 1;
        end
      end
      prev_sclk = bus_if.sclk;
      tick();
    end
  endtask

  initial begin
    int            low, rises, vcyc, rdy, pulses, gap, p1, p2, cnt;
    logic [DW-1:0] mbits, rxw, r1, r2;

    reset = 1'b1;
    loopback = 1'b1;
    slave_bit = 1'b0;
    bus_if.cfg_cpol = 1'b0;
    bus_if.cfg_cpha = 1'b0;
    bus_if.cfg_clk_div = '0;
    bus_if.tx_data = '0;
    bus_if.tx_valid = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("rst_busy",     32'(bus_if.busy),     32'd0);
    check("rst_cs_n",     32'(bus_if.cs_n),     32'd1);
    check("rst_sclk",     32'(bus_if.sclk),     32'd0);
    check("rst_mosi",     32'(bus_if.mosi),     32'd0);
    check("rst_rx_data",  32'(bus_if.rx_data),  32'd0);
    check("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    reset = 1'b0;
    tick();

    // Mode 0, H=1, loopback 0xA5.
    start(1'b0, 1'b0, 8'd0, 8'hA5);
    check("m0_lead_sclk", 32'(bus_if.sclk), 32'd0);
    watch(100, 1'b0, 8'h00, 0, 0, low, rises, mbits, vcyc, rxw, rdy);
    check("m0_low",   32'(low),   32'd18);
    check("m0_rises", 32'(rises), 32'd8);
    check("m0_mosi",  32'(mbits), 32'hA5);
    check("m0_vcyc",  32'(vcyc),  32'd19);
    check("m0_rx",    32'(rxw),   32'hA5);
    check("m0_rdy",   32'(rdy),   32'd0);

    // Mode 3, H=4, slave returns 0xC3.
    bus_if.cfg_cpol = 1'b1;
    tick();
    check("m3_idle_high", 32'(bus_if.sclk), 32'd1);
    loopback = 1'b0;
    start(1'b1, 1'b1, 8'd3, 8'h3C);
    watch(200, 1'b1, 8'hC3, 0, 0, low, rises, mbits, vcyc, rxw, rdy);
    check("m3_low",   32'(low),   32'd72);
    check("m3_rises", 32'(rises), 32'd8);
    check("m3_mosi",  32'(mbits), 32'h3C);
    check("m3_vcyc",  32'(vcyc),  32'd73);
    check("m3_rx",    32'(rxw),   32'hC3);
    loopback = 1'b1;

    // Back-to-back: tx_valid held across the completion cycle.
    bus_if.cfg_cpol = 1'b0;
    bus_if.cfg_cpha = 1'b0;
    bus_if.cfg_clk_div = 8'd0;
    bus_if.tx_data = 8'h01;
    bus_if.tx_valid = 1'b1;
    check("b2b_ready", 32'(bus_if.tx_ready), 32'd1);
    tick();
    bus_if.tx_data = 8'h80;
    pulses = 0; gap = 0; p1 = -1; p2 = -1; r1 = '0; r2 = '0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (bus_if.rx_valid) begin
        pulses++;
        if (pulses == 1) begin p1 = cyc; r1 = bus_if.rx_data; end
        else begin p2 = cyc; r2 = bus_if.rx_data; end
      end
      if (pulses == 1 && bus_if.cs_n) gap++;
      if (pulses == 1 && !bus_if.cs_n) bus_if.tx_valid = 1'b0;
      if (pulses == 2) break;
      tick();
    end
    bus_if.tx_valid = 1'b0;
    check("b2b_p1",  32'(p1),  32'd19);
    check("b2b_r1",  32'(r1),  32'h01);
    check("b2b_gap", 32'(gap), 32'd1);
    check("b2b_p2",  32'(p2),  32'd38);
    check("b2b_r2",  32'(r2),  32'h80);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!bus_if.cs_n) cnt++;
    end
    check("b2b_no_third", 32'(cnt), 32'd0);

    // Config flipped mid-frame: frame keeps latched cpol=0, H=2.
    start(1'b0, 1'b0, 8'd1, 8'h5A);
    watch(200, 1'b0, 8'h00, 6, 1, low, rises, mbits, vcyc, rxw, rdy);
    check("flip_low",   32'(low),   32'd36);
    check("flip_rises", 32'(rises), 32'd8);
    check("flip_vcyc",  32'(vcyc),  32'd37);
    check("flip_rx",    32'(rxw),   32'h5A);
    check("flip_done_sclk", 32'(bus_if.sclk), 32'd0);
    tick();
    check("flip_idle_new_cpol", 32'(bus_if.sclk), 32'd1);
    // Next frame runs with the new values: mode 2, H=6.
    start(1'b1, 1'b0, 8'd5, 8'h5A);
    watch(300, 1'b0, 8'h00, 0, 0, low, rises, mbits, vcyc, rxw, rdy);
    check("new_low",  32'(low),  32'd108);
    check("new_vcyc", 32'(vcyc), 32'd109);
    check("new_rx",   32'(rxw),  32'h5A);

    // Reset at edge 5 (edge k lands entering cycle k+1 when H=1).
    start(1'b0, 1'b0, 8'd0, 8'hFF);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    check("rmid_cs_n",     32'(bus_if.cs_n),     32'd1);
    check("rmid_busy",     32'(bus_if.busy),     32'd0);
    check("rmid_sclk",     32'(bus_if.sclk),     32'd0);
    check("rmid_rx_data",  32'(bus_if.rx_data),  32'd0);
    check("rmid_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.rx_valid || !bus_if.cs_n) cnt++;
    end
    check("rmid_quiet", 32'(cnt), 32'd0);
    start(1'b0, 1'b0, 8'd0, 8'h96);
    watch(100, 1'b0, 8'h00, 0, 0, low, rises, mbits, vcyc, rxw, rdy);
    check("rmid_next_vcyc", 32'(vcyc), 32'd19);
    check("rmid_next_rx",   32'(rxw),  32'h96);

    // tx_valid pulsed while busy is dropped.
    start(1'b0, 1'b0, 8'd0, 8'h33);
    watch(100, 1'b0, 8'h00, 5, 2, low, rises, mbits, vcyc, rxw, rdy);
    check("busy_vcyc", 32'(vcyc), 32'd19);
    check("busy_rx",   32'(rxw),  32'h33);
    check("busy_rdy",  32'(rdy),  32'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!bus_if.cs_n || bus_if.rx_valid) cnt++;
    end
    check("busy_no_second", 32'(cnt), 32'd0);

    // Maximum divider: H = 256.
    start(1'b0, 1'b0, 8'hFF, 8'hC3);
    watch(5000, 1'b0, 8'h00, 0, 0, low, rises, mbits, vcyc, rxw, rdy);
    check("max_low",   32'(low),   32'd4608);
    check("max_rises", 32'(rises), 32'd8);
    check("max_vcyc",  32'(vcyc),  32'd4609);
    check("max_rx",    32'(rxw),   32'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
